// File: rtl/wb_sram_pkg.sv
// Shared types and helpers for the Wishbone-to-asynchronous-SRAM controller.
package wb_sram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        MERGE   = 3'd2,
        WR      = 3'd3,
        WR_HOLD = 3'd4,
        ACK     = 3'd5
    } state_t;

    localparam int SRAM_WORDS = 1 << 20;

    // Lanes with sel set come from new_w, the rest keep the word read from the SRAM.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] w_res;
        w_res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) w_res[8*i +: 8] = new_w[8*i +: 8];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// Single-cycle Wishbone slave driving one 1M x 32 async SRAM bank; partial writes via read-modify-write.
// Latency: read W+2, full write W+3, partial write 2W+5, sel==0 one cycle; one request in flight.
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wishbone_addr_i,
    input  logic [31:0]       wishbone_data_i,
    input  logic [3:0]        wishbone_select_i,
    input  logic              wishbone_we_i,
    input  logic              wishbone_stb_i,
    input  logic              wishbone_cyc_i,
    output logic [31:0]       wishbone_data_o,
    output logic              wishbone_ack_o,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [31:0]       ram_data,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we
);

    localparam logic [2:0] WC = 3'(WAIT_CYCLES);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdat;
    logic [31:0]       r_dato;
    logic [3:0]        r_sel;
    logic              r_wr;
    logic              r_ce;
    logic              r_oe;
    logic              r_we;
    logic              r_drv;
    logic              r_ack;

    wire w_req = wishbone_cyc_i & wishbone_stb_i;
    wire w_unused = &{1'b0, wishbone_addr_i[31:ADDR_W+2], wishbone_addr_i[1:0]};

    assign ram_data        = r_drv ? r_wdat : 32'bz;
    assign ram_addr        = r_addr;
    assign ram_ce          = r_ce;
    assign ram_oe          = r_oe;
    assign ram_we          = r_we;
    assign wishbone_data_o = r_dato;
    assign wishbone_ack_o  = r_ack;

    // Every strobe changes only on a state transition, so each is a plain flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_wdat  <= 32'd0;
            r_dato  <= 32'd0;
            r_sel   <= 4'd0;
            r_wr    <= 1'b0;
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            r_drv   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr <= wishbone_addr_i[ADDR_W+1:2];
                        r_wdat <= wishbone_data_i;
                        r_sel  <= wishbone_select_i;
                        r_wr   <= wishbone_we_i;
                        if (wishbone_select_i == 4'd0) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else if (!wishbone_we_i || wishbone_select_i != 4'hF) begin
                            r_state <= RD;
                            r_cnt   <= WC;
                            r_ce    <= 1'b0;
                            r_oe    <= 1'b0;
                        end else begin
                            r_state <= WR;
                            r_cnt   <= WC;
                            r_ce    <= 1'b0;
                            r_we    <= 1'b0;
                            r_drv   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_oe <= 1'b1;
                        if (r_wr) begin
                            // Merge now; MERGE is then purely the bus turnaround cycle.
                            r_wdat  <= byte_merge(ram_data, r_wdat, r_sel);
                            r_state <= MERGE;
                        end else begin
                            r_dato  <= ram_data;
                            r_ce    <= 1'b1;
                            r_ack   <= wishbone_cyc_i;
                            r_state <= ACK;
                        end
                    end
                end
                MERGE: begin
                    r_state <= WR;
                    r_cnt   <= WC;
                    r_we    <= 1'b0;
                    r_drv   <= 1'b1;
                end
                WR: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_we    <= 1'b1;
                        r_state <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    r_ce    <= 1'b1;
                    r_drv   <= 1'b0;
                    r_ack   <= wishbone_cyc_i;
                    r_state <= ACK;
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ce    <= 1'b1;
                    r_oe    <= 1'b1;
                    r_we    <= 1'b1;
                    r_drv   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl with a small behavioural async SRAM model.
// Latency: n/a (bench); checks ack edges against the specification.
// Backpressure: requests held until ack or deliberate cyc drop.
module tb_wb_sram_ctrl;
    import wb_sram_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] wb_addr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic [31:0] wishbone_data_o;
    logic        wishbone_ack_o;
    logic [19:0] ram_addr;
    wire  [31:0] ram_data;
    logic        ram_ce;
    logic        ram_oe;
    logic        ram_we;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:15] = '{4: 32'hDEADBEEF, 9: 32'h11223344, default: 32'h0};

    wb_sram_ctrl #(.WAIT_CYCLES(1), .ADDR_W(20)) dut (
        .clk              (clk),
        .rst              (rst),
        .wishbone_addr_i  (wb_addr),
        .wishbone_data_i  (wb_dat),
        .wishbone_select_i(wb_sel),
        .wishbone_we_i    (wb_we),
        .wishbone_stb_i   (wb_stb),
        .wishbone_cyc_i   (wb_cyc),
        .wishbone_data_o  (wishbone_data_o),
        .wishbone_ack_o   (wishbone_ack_o),
        .ram_addr         (ram_addr),
        .ram_data         (ram_data),
        .ram_ce           (ram_ce),
        .ram_oe           (ram_oe),
        .ram_we           (ram_we)
    );

    assign ram_data = (!ram_ce && !ram_oe && ram_we) ? mem[ram_addr[3:0]] : 32'bz;

    always @(posedge ram_we) begin
        if (!ram_ce) mem[ram_addr[3:0]] <= ram_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one request for 15 cycles, recording per-cycle strobe masks (bit c = cycle c after the sampling edge).
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, input int drop_c,
                          output int ack_c, output logic [31:0] rd,
                          output logic [15:0] ce_m, output logic [15:0] oe_m,
                          output logic [15:0] we_m, output logic [15:0] drv_m,
                          output logic [19:0] addr1);
        @(negedge clk);
        wb_addr = a; wb_dat = d; wb_sel = s; wb_we = w; wb_cyc = 1'b1; wb_stb = 1'b1;
        ack_c = -1; rd = 32'h0; ce_m = '0; oe_m = '0; we_m = '0; drv_m = '0; addr1 = '0;
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            if (c == 1) addr1 = ram_addr;
            ce_m[c]  = !ram_ce;
            oe_m[c]  = !ram_oe;
            we_m[c]  = !ram_we;
            drv_m[c] = dut.r_drv;
            if (wishbone_ack_o === 1'b1 && ack_c < 0) begin
                ack_c = c;
                rd = wishbone_data_o;
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
            if (c == drop_c) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
        end
    endtask

    int          ack_c;
    logic [31:0] rd;
    logic [15:0] ce_m, oe_m, we_m, drv_m;
    logic [19:0] addr1;

    initial begin
        rst = 1'b0; wb_addr = 0; wb_dat = 0; wb_sel = 0; wb_we = 0; wb_stb = 0; wb_cyc = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", dut.r_state === IDLE, 32'(dut.r_state), 32'(IDLE));
        chk("rst_ce", ram_ce === 1'b1, 32'(ram_ce), 32'h1);
        chk("rst_oe", ram_oe === 1'b1, 32'(ram_oe), 32'h1);
        chk("rst_we", ram_we === 1'b1, 32'(ram_we), 32'h1);
        chk("rst_addr", ram_addr === 20'h0, 32'(ram_addr), 32'h0);
        chk("rst_ack", wishbone_ack_o === 1'b0, 32'(wishbone_ack_o), 32'h0);
        chk("rst_dato", wishbone_data_o === 32'h0, wishbone_data_o, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        access(32'h0000_0010, 32'h0, 4'hF, 1'b0, 0, ack_c, rd, ce_m, oe_m, we_m, drv_m, addr1);
        chk("rd_addr", addr1 === 20'h4, 32'(addr1), 32'h4);
        chk("rd_ack_edge", ack_c === 3, 32'(ack_c), 32'd3);
        chk("rd_data", rd === 32'hDEADBEEF, rd, 32'hDEADBEEF);
        chk("rd_oe_mask", oe_m === 16'h0006, 32'(oe_m), 32'h0006);
        chk("rd_ce_mask", ce_m === 16'h0006, 32'(ce_m), 32'h0006);
        chk("rd_we_mask", we_m === 16'h0000, 32'(we_m), 32'h0000);

        access(32'h0000_001C, 32'h12345678, 4'hF, 1'b1, 0, ack_c, rd, ce_m, oe_m, we_m, drv_m, addr1);
        chk("fw_ack_edge", ack_c === 4, 32'(ack_c), 32'd4);
        chk("fw_we_mask", we_m === 16'h0006, 32'(we_m), 32'h0006);
        chk("fw_drv_mask", drv_m === 16'h000E, 32'(drv_m), 32'h000E);
        chk("fw_ce_mask", ce_m === 16'h000E, 32'(ce_m), 32'h000E);
        chk("fw_oe_mask", oe_m === 16'h0000, 32'(oe_m), 32'h0000);
        access(32'h0000_001C, 32'h0, 4'hF, 1'b0, 0, ack_c, rd, ce_m, oe_m, we_m, drv_m, addr1);
        chk("fw_readback", rd === 32'h12345678, rd, 32'h12345678);
        chk("fw_rb_ack_edge", ack_c === 3, 32'(ack_c), 32'd3);

        access(32'h0000_0024, 32'h0000AB00, 4'b0010, 1'b1, 0, ack_c, rd, ce_m, oe_m, we_m, drv_m, addr1);
        chk("pw_ack_edge", ack_c === 7, 32'(ack_c), 32'd7);
        chk("pw_oe_mask", oe_m === 16'h0006, 32'(oe_m), 32'h0006);
        chk("pw_we_mask", we_m === 16'h0030, 32'(we_m), 32'h0030);
        chk("pw_drv_mask", drv_m === 16'h0070, 32'(drv_m), 32'h0070);
        chk("pw_ce_mask", ce_m === 16'h007E, 32'(ce_m), 32'h007E);
        chk("pw_no_overlap", (oe_m & we_m) === 16'h0000, 32'(oe_m & we_m), 32'h0000);
        chk("pw_mem", mem[9] === 32'h1122AB44, mem[9], 32'h1122AB44);
        access(32'h0000_0024, 32'h0, 4'hF, 1'b0, 0, ack_c, rd, ce_m, oe_m, we_m, drv_m, addr1);
        chk("pw_readback", rd === 32'h1122AB44, rd, 32'h1122AB44);

        access(32'h0000_0028, 32'hFFFF_FFFF, 4'b0000, 1'b1, 0, ack_c, rd, ce_m, oe_m, we_m, drv_m, addr1);
        chk("s0_ack_edge", ack_c === 1, 32'(ack_c), 32'd1);
        chk("s0_ce_mask", ce_m === 16'h0000, 32'(ce_m), 32'h0000);
        chk("s0_oe_mask", oe_m === 16'h0000, 32'(oe_m), 32'h0000);
        chk("s0_we_mask", we_m === 16'h0000, 32'(we_m), 32'h0000);
        chk("s0_mem", mem[10] === 32'h0, mem[10], 32'h0);

        access(32'h0000_002C, 32'hCAFEF00D, 4'hF, 1'b1, 2, ack_c, rd, ce_m, oe_m, we_m, drv_m, addr1);
        chk("ab_no_ack", ack_c === -1, 32'(ack_c), 32'hFFFF_FFFF);
        chk("ab_we_mask", we_m === 16'h0006, 32'(we_m), 32'h0006);
        chk("ab_ce_mask", ce_m === 16'h000E, 32'(ce_m), 32'h000E);
        chk("ab_mem", mem[11] === 32'hCAFEF00D, mem[11], 32'hCAFEF00D);

        @(negedge clk);
        wb_addr = 32'h0000_0030; wb_dat = 32'hAAAA5555; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        chk("mr_we_low", ram_we === 1'b0, 32'(ram_we), 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("mr_we_async", ram_we === 1'b1, 32'(ram_we), 32'h1);
        chk("mr_ce_async", ram_ce === 1'b1, 32'(ram_ce), 32'h1);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_state", dut.r_state === IDLE, 32'(dut.r_state), 32'(IDLE));
        chk("mr_ce", ram_ce === 1'b1, 32'(ram_ce), 32'h1);
        chk("mr_oe", ram_oe === 1'b1, 32'(ram_oe), 32'h1);
        chk("mr_we", ram_we === 1'b1, 32'(ram_we), 32'h1);
        chk("mr_addr", ram_addr === 20'h0, 32'(ram_addr), 32'h0);
        chk("mr_ack", wishbone_ack_o === 1'b0, 32'(wishbone_ack_o), 32'h0);
        chk("mr_dato", wishbone_data_o === 32'h0, wishbone_data_o, 32'h0);
        chk("mr_drv", dut.r_drv === 1'b0, 32'(dut.r_drv), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
